// File: rtl/rapid_pkg.sv
// -----------------------------------------------------------------------------
// rapid_pkg
// Shared definitions for the rapid core front end.
//   XLEN / ILEN     : address and instruction widths
//   RAPID_RESET_PC  : default first fetch address after reset
//   fetch_entry_t   : {pc, instr} pair buffered between fetch and decode
//   pc_next()       : sequential PC step (+4, wraps mod 2^32)
//   pc_align()      : clears the byte-offset bits of a PC
// -----------------------------------------------------------------------------
package rapid_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RAPID_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP        = 32'h0000_0004;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // Next sequential fetch address; natural 32-bit overflow gives the wrap.
  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + PC_STEP;
  endfunction

  // Word-align a PC by dropping the two byte-offset bits.
  function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/rapid_fetch_fifo.sv
// -----------------------------------------------------------------------------
// rapid_fetch_fifo
// First-word-fall-through synchronous FIFO of fetch_entry_t.
// Push and pop in the same cycle are both honoured at any fill level
// (including full, where the written slot is the one being vacated).
// Flush has priority over push and pop.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data at the tail (ignored when full without pop)
//   push_data  : entry to write
//   pop        : remove the head (ignored when empty)
//   flush      : empty the FIFO at the next edge
//   head       : current head entry (valid when !empty)
//   count      : number of stored entries
//   full/empty : status flags
// -----------------------------------------------------------------------------
module rapid_fetch_fifo
  import rapid_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  fetch_entry_t     entries_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  logic             full_s;
  logic             empty_s;
  logic             do_push_s;
  logic             do_pop_s;
  logic [CNT_W-1:0] count_next_s;

  // Status flags and qualified push/pop strobes.
  always_comb begin
    full_s    = (count_r == CNT_FULL);
    empty_s   = (count_r == CNT_ZERO);
    do_pop_s  = pop && !empty_s;
    do_push_s = push && (!full_s || do_pop_s);
    if (do_push_s && !do_pop_s) begin
      count_next_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (do_pop_s && !do_push_s) begin
      count_next_s = count_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_next_s = count_r;
    end
  end

  // Pointer and occupancy registers; flush behaves like a reset.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_next_s;
    end
  end

  // Entry storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (do_push_s && !flush) begin
      entries_r[wr_ptr_r] <= push_data;
    end
  end

  assign head  = entries_r[rd_ptr_r];
  assign count = count_r;
  assign full  = full_s;
  assign empty = empty_s;

endmodule

// File: rtl/rapid_fetch.sv
// -----------------------------------------------------------------------------
// rapid_fetch
// Instruction fetch stage feeding decode.
//   - Issues word-aligned requests on the imem req/gnt interface, keeping at
//     most MAX_OUTSTANDING accepted-but-unanswered requests and never more live
//     requests than the buffer can absorb.
//   - Tags in-order responses with their PC and buffers them in a FWFT FIFO.
//   - Presents the FIFO head to decode with a valid/ready handshake.
//   - On pc_load_i flushes the buffer, restarts at pc_target_i and drops every
//     response belonging to requests accepted up to and including that cycle.
// Optional feature macro: RAPID_FETCH_MISALIGN_EN
//   Defined   : a redirect to a non-word-aligned target raises
//               fetch_misaligned_o (next cycle) and halts fetching until the
//               next aligned redirect or reset.
//   Undefined : fetch_misaligned_o is absent and target bits [1:0] are ignored.
// Ports:
//   clk_i, rst_i             : clock, synchronous active-high reset
//   imem_req_o, imem_addr_o  : fetch request and word address
//   imem_gnt_i               : request accepted this cycle
//   imem_rvalid_i/rdata_i    : in-order response
//   instr_valid_o, instr_o, pc_o, instr_ready_i : decode handshake
//   pc_load_i, pc_target_i   : redirect
//   fetch_misaligned_o       : misaligned-redirect flag (feature only)
// -----------------------------------------------------------------------------
module rapid_fetch
  import rapid_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC        = RAPID_RESET_PC,
  parameter int              FIFO_DEPTH      = 2,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [ILEN-1:0] imem_rdata_i,
  output logic            instr_valid_o,
  output logic [ILEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  input  logic            instr_ready_i,
  input  logic            pc_load_i,
  input  logic [XLEN-1:0] pc_target_i
`ifdef RAPID_FETCH_MISALIGN_EN
  ,
  output logic            fetch_misaligned_o
`endif
);

  // Outstanding never exceeds MAX_OUTSTANDING <= FIFO_DEPTH, so one counter
  // width serves FIFO occupancy, outstanding and discard alike.
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUTSTANDING);
  localparam logic [SUM_W-1:0] DEPTH_C   = SUM_W'(FIFO_DEPTH);

  logic [XLEN-1:0] fetch_pc_r;
  logic [XLEN-1:0] resp_pc_r;
  logic [CNT_W-1:0] outstanding_r;
  logic [CNT_W-1:0] discard_r;

  logic [XLEN-1:0]  fetch_pc_next_s;
  logic [XLEN-1:0]  resp_pc_next_s;
  logic [CNT_W-1:0] outstanding_next_s;
  logic [CNT_W-1:0] discard_next_s;

  logic [XLEN-1:0]  target_s;
  logic             halt_s;
  logic             instr_valid_s;
  logic             pop_s;
  logic             push_s;
  logic [CNT_W-1:0] live_s;
  logic [CNT_W-1:0] fifo_eff_s;
  logic             credit_ok_s;
  logic             req_s;
  logic             accept_s;

  fetch_entry_t     push_entry_s;
  fetch_entry_t     head_s;
  logic [CNT_W-1:0] fifo_count_s;
  logic             fifo_empty_s;
  logic             unused_fifo_full_s;

  assign target_s = pc_align(pc_target_i);

`ifdef RAPID_FETCH_MISALIGN_EN
  logic misaligned_r;

  // Misaligned-redirect flag: set/cleared by each redirect, held otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      misaligned_r <= 1'b0;
    end else if (pc_load_i) begin
      misaligned_r <= (pc_target_i[1:0] != 2'b00);
    end else begin
      misaligned_r <= misaligned_r;
    end
  end

  assign halt_s             = misaligned_r;
  assign fetch_misaligned_o = misaligned_r;
`else
  logic unused_target_bits_s;

  assign halt_s               = 1'b0;
  assign unused_target_bits_s = ^pc_target_i[1:0];
`endif

  // Handshake, credit check and request qualification.
  // A head leaving this cycle frees its slot before any response issued now
  // can land (responses are >= 1 cycle after accept), so the pop is credited
  // immediately; this is what sustains one instruction per cycle with a
  // two-entry buffer.
  always_comb begin
    instr_valid_s = !rst_i && !fifo_empty_s && !pc_load_i;
    pop_s         = instr_valid_s && instr_ready_i;
    live_s        = outstanding_r - discard_r;
    if (pop_s) begin
      fifo_eff_s = fifo_count_s - CNT_ONE;
    end else begin
      fifo_eff_s = fifo_count_s;
    end
    credit_ok_s = (({1'b0, fifo_eff_s} + {1'b0, live_s}) < DEPTH_C);
    req_s       = !rst_i && (outstanding_r < MAX_OUT_C) && credit_ok_s && !halt_s;
    accept_s    = req_s && imem_gnt_i;
    outstanding_next_s = outstanding_r
                       + {{(CNT_W-1){1'b0}}, accept_s}
                       - {{(CNT_W-1){1'b0}}, imem_rvalid_i};
  end

  // Next-state for PCs, discard count and FIFO push; redirect wins.
  always_comb begin
    fetch_pc_next_s = fetch_pc_r;
    resp_pc_next_s  = resp_pc_r;
    discard_next_s  = discard_r;
    push_s          = 1'b0;
    push_entry_s    = '{pc: resp_pc_r, instr: imem_rdata_i};
    if (pc_load_i) begin
      // Everything accepted up to and including now is stale; a response
      // arriving now is already removed from outstanding_next_s.
      fetch_pc_next_s = target_s;
      resp_pc_next_s  = target_s;
      discard_next_s  = outstanding_next_s;
      push_s          = 1'b0;
    end else begin
      if (accept_s) begin
        fetch_pc_next_s = pc_next(fetch_pc_r);
      end else begin
        fetch_pc_next_s = fetch_pc_r;
      end
      if (imem_rvalid_i) begin
        if (discard_r != CNT_ZERO) begin
          discard_next_s = discard_r - CNT_ONE;
          push_s         = 1'b0;
        end else begin
          push_s         = 1'b1;
          resp_pc_next_s = pc_next(resp_pc_r);
        end
      end else begin
        push_s = 1'b0;
      end
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_r    <= RESET_PC;
      resp_pc_r     <= RESET_PC;
      outstanding_r <= CNT_ZERO;
      discard_r     <= CNT_ZERO;
    end else begin
      fetch_pc_r    <= fetch_pc_next_s;
      resp_pc_r     <= resp_pc_next_s;
      outstanding_r <= outstanding_next_s;
      discard_r     <= discard_next_s;
    end
  end

  rapid_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .flush     (pc_load_i),
    .head      (head_s),
    .count     (fifo_count_s),
    .full      (unused_fifo_full_s),
    .empty     (fifo_empty_s)
  );

  assign imem_req_o    = req_s;
  assign imem_addr_o   = fetch_pc_r;
  assign instr_valid_o = instr_valid_s;
  assign instr_o       = head_s.instr;
  assign pc_o          = head_s.pc;

endmodule
